demux_lane_collector: RTL

- Sits directly downstream of the 1-to-4 bit demux; consumes its 4-bit one-hot-routed output together with the select that steered it.
- Accumulates each lane's serial bits into WORD_W-bit words and buffers one completed word per lane.
- Arbitrates round-robin among lanes onto a single valid/ready word output.

---
 rtl/demux_collector_pkg.sv | 9 +
 rtl/demux_lane_accum.sv | 82 ++++++++
 rtl/demux_lane_collector.sv | 96 +++++++++
 3 files changed

// File: rtl/demux_collector_pkg.sv
// Shared constants and types for the demux lane collector.
package demux_collector_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage

// File: rtl/demux_lane_accum.sv
// One lane of the collector: serial-to-word accumulator, a single-word
// holding buffer with its pending flag, and a sticky overflow flag.
module demux_lane_accum #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              bit_data,
  input  logic              flush,
  input  logic              clear_ovf,
  input  logic              drain,
  output logic              pend,
  output logic [WORD_W-1:0] holding,
  output logic              overflow
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] filled;
  logic              last_bit;
  logic              complete;
  logic              drop;

  // Accumulator with the incoming bit merged in at the current position.
  always_comb begin
    filled      = acc;
    filled[cnt] = bit_data;
  end

  assign last_bit = (cnt == CNT_W'(WORD_W - 1));
  assign complete = bit_en && !flush && last_bit;
  // A full holding slot only blocks the new word if the arbiter is not
  // taking it out in the same cycle.
  assign drop     = complete && pend && !drain;

  // Bit counter and partial word; flush discards a coincident bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (flush) begin
      cnt <= '0;
      acc <= '0;
    end else if (bit_en) begin
      if (last_bit) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= filled;
      end
    end
  end

  // Holding buffer and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holding <= '0;
      pend    <= 1'b0;
    end else if (complete && !drop) begin
      holding <= filled;
      pend    <= 1'b1;
    end else if (drain) begin
      pend    <= 1'b0;
    end
  end

  // Sticky overflow; a new drop wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_lane_collector.sv
// Collects the four demux lanes into words and round-robins the completed
// words onto a single valid/ready output register.
module demux_lane_collector
  import demux_collector_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bit_valid_i,
  input  logic [1:0]        sel_i,
  input  logic [3:0]        lane_data_i,
  input  logic              flush_i,
  input  logic              clear_ovf_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [1:0]        word_lane_o,
  output logic [3:0]        overflow_o
);

  logic [NUM_LANES-1:0] bit_en;
  logic [NUM_LANES-1:0] pend;
  logic [NUM_LANES-1:0] drain;
  logic [WORD_W-1:0]    holding [NUM_LANES];

  lane_idx_t ptr;
  lane_idx_t grant;
  lane_idx_t cand;
  logic      any_pend;
  logic      load;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // Only the selected lane sees the bit; the other demux outputs are ignored.
    assign bit_en[i] = bit_valid_i && (sel_i == lane_idx_t'(i));

    demux_lane_accum #(
      .WORD_W(WORD_W)
    ) u_accum (
      .clk      (clk_i),
      .rst      (rst_i),
      .bit_en   (bit_en[i]),
      .bit_data (lane_data_i[i]),
      .flush    (flush_i),
      .clear_ovf(clear_ovf_i),
      .drain    (drain[i]),
      .pend     (pend[i]),
      .holding  (holding[i]),
      .overflow (overflow_o[i])
    );
  end

  // Round-robin search starting just after the last granted lane.
  always_comb begin
    grant    = ptr;
    any_pend = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = ptr + lane_idx_t'(k);
      if (!any_pend && pend[cand]) begin
        grant    = cand;
        any_pend = 1'b1;
      end
    end
  end

  assign load = !word_valid_o || word_ready_i;

  // Pop the granted lane's holding buffer when the output register loads.
  always_comb begin
    drain = '0;
    if (load && any_pend) begin
      drain[grant] = 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_valid_o <= 1'b0;
      word_data_o  <= '0;
      word_lane_o  <= '0;
      ptr          <= lane_idx_t'(NUM_LANES - 1);
    end else if (load) begin
      if (any_pend) begin
        word_valid_o <= 1'b1;
        word_data_o  <= holding[grant];
        word_lane_o  <= grant;
        ptr          <= grant;
      end else begin
        word_valid_o <= 1'b0;
      end
    end
  end

endmodule
